acc_bank: RTL and testbench

Multi-channel, parametrised accumulator bank: the successor to the single 5-bit accumulator in the datapath. It holds `CHANNELS` independent running sums of `ACC_WIDTH` bits each. Commands (add, subtract, load, clear) are accepted over a valid/ready handshake, and the updated channel value is returned on a registered valid/ready result port. It sits between the sample front-end and the result formatter, and replaces per-channel instances of the old accumulator.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_alu.sv | 59 +++++
 rtl/acc_bank.sv | 115 +++++++++++
 tb/tb_acc_bank.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// ============================================================================
// Module   : acc_pkg
// Brief    : Command encodings shared by the accumulator bank and its ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam logic [1:0] ACC_OP_ADD   = 2'b00;
    localparam logic [1:0] ACC_OP_SUB   = 2'b01;
    localparam logic [1:0] ACC_OP_LOAD  = 2'b10;
    localparam logic [1:0] ACC_OP_CLEAR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/acc_alu.sv
// ============================================================================
// Module   : acc_alu
// Brief    : Combinational next-value/overflow logic for one accumulator.
//            ACC_SATURATE_EN clamps instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_alu
    import acc_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int ACC_WIDTH = 8
) (
    input  logic [IN_WIDTH-1:0]  i_operand,
    input  logic [ACC_WIDTH-1:0] i_cur,
    input  logic [1:0]           i_op,
    output logic [ACC_WIDTH-1:0] o_result,
    output logic                 o_ovf
);

    logic [ACC_WIDTH:0] w_opnd;
    logic [ACC_WIDTH:0] w_sum;
    logic [ACC_WIDTH:0] w_diff;

    // One extra bit holds the carry of ADD or the borrow of SUB.
    assign w_opnd = (ACC_WIDTH+1)'(i_operand);
    assign w_sum  = {1'b0, i_cur} + w_opnd;
    assign w_diff = {1'b0, i_cur} - w_opnd;

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        case (i_op)
            ACC_OP_ADD: begin
                o_ovf = w_sum[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
                o_result = w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
`else
                o_result = w_sum[ACC_WIDTH-1:0];
`endif
            end
            ACC_OP_SUB: begin
                o_ovf = w_diff[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
                o_result = w_diff[ACC_WIDTH] ? '0 : w_diff[ACC_WIDTH-1:0];
`else
                o_result = w_diff[ACC_WIDTH-1:0];
`endif
            end
            ACC_OP_LOAD:  o_result = w_opnd[ACC_WIDTH-1:0];
            ACC_OP_CLEAR: o_result = '0;
            default:      o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/acc_bank.sv
// ============================================================================
// Module   : acc_bank
// Brief    : Multi-channel accumulator bank with valid/ready command and
//            registered result ports. Build option: ACC_SATURATE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_bank
    import acc_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int ACC_WIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int CH_BITS   = 2
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 clock_enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_BITS-1:0]   in_chan,
    input  logic [1:0]           in_op,
    input  logic [IN_WIDTH-1:0]  acc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_BITS-1:0]   out_chan,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_ovf,
    output logic [CHANNELS-1:0]  ovf_sticky
);

    logic [ACC_WIDTH-1:0] r_acc [CHANNELS];
    logic [CHANNELS-1:0]  r_sticky;
    logic                 r_out_valid;
    logic [CH_BITS-1:0]   r_out_chan;
    logic [ACC_WIDTH-1:0] r_acc_out;
    logic                 r_out_ovf;

    logic                 w_accept;
    logic                 w_chan_ok;
    logic [ACC_WIDTH-1:0] w_cur;
    logic [ACC_WIDTH-1:0] w_new;
    logic                 w_alu_ovf;
    logic                 w_sticky_clr;

    assign in_ready     = clock_enable & reset & (~r_out_valid | out_ready);
    assign w_accept     = in_valid & in_ready;
    assign w_sticky_clr = (in_op == ACC_OP_LOAD) || (in_op == ACC_OP_CLEAR);

    // Channel indices beyond CHANNELS match nothing, so they read as invalid.
    always_comb begin
        w_chan_ok = 1'b0;
        w_cur     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_chan == CH_BITS'(i)) begin
                w_chan_ok = 1'b1;
                w_cur     = r_acc[i];
            end
        end
    end

    acc_alu #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_alu (
        .i_operand (acc_in),
        .i_cur     (w_cur),
        .i_op      (in_op),
        .o_result  (w_new),
        .o_ovf     (w_alu_ovf)
    );

    always_ff @(posedge pclk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_sticky    <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_acc_out   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clock_enable) begin
            if (w_accept && w_chan_ok) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (in_chan == CH_BITS'(i)) begin
                        r_acc[i] <= w_new;
                        if (w_sticky_clr) begin
                            r_sticky[i] <= 1'b0;
                        end else if (w_alu_ovf) begin
                            r_sticky[i] <= 1'b1;
                        end
                    end
                end
                // A new result overwrites whatever is being consumed this edge.
                r_out_valid <= 1'b1;
                r_out_chan  <= in_chan;
                r_acc_out   <= w_new;
                r_out_ovf   <= w_alu_ovf;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_chan   = r_out_chan;
    assign acc_out    = r_acc_out;
    assign out_ovf    = r_out_ovf;
    assign ovf_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_acc_bank.sv
// ============================================================================
// Module   : tb_acc_bank
// Brief    : Directed self-checking bench for acc_bank (CH_BITS widened to 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_acc_bank;

    localparam int IW = 5;
    localparam int AW = 8;
    localparam int CH = 4;
    localparam int CB = 3;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          pclk;
    logic          reset;
    logic          clock_enable;
    logic          in_valid;
    logic          in_ready;
    logic [CB-1:0] in_chan;
    logic [1:0]    in_op;
    logic [IW-1:0] acc_in;
    logic          out_valid;
    logic          out_ready;
    logic [CB-1:0] out_chan;
    logic [AW-1:0] acc_out;
    logic          out_ovf;
    logic [CH-1:0] ovf_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    acc_bank #(
        .IN_WIDTH  (IW),
        .ACC_WIDTH (AW),
        .CHANNELS  (CH),
        .CH_BITS   (CB)
    ) dut (
        .pclk         (pclk),
        .reset        (reset),
        .clock_enable (clock_enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_chan      (in_chan),
        .in_op        (in_op),
        .acc_in       (acc_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chan     (out_chan),
        .acc_out      (acc_out),
        .out_ovf      (out_ovf),
        .ovf_sticky   (ovf_sticky)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    // Present one command, wait (bounded) for acceptance, return 1 after the edge.
    task automatic cmd(input logic [CB-1:0] ch, input logic [1:0] op, input logic [IW-1:0] val);
        int n;
        @(negedge pclk);
        in_valid = 1'b1;
        in_chan  = ch;
        in_op    = op;
        acc_in   = val;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL cmd_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
        else
            n_pass++;
        @(posedge pclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        clock_enable = 1'b1;
        in_valid     = 1'b0;
        in_chan      = '0;
        in_op        = 2'b00;
        acc_in       = '0;
        out_ready    = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({in_ready, out_valid, out_chan, acc_out, out_ovf, ovf_sticky} !== 18'b0)
            $display("FAIL reset_state: got %b, required all zero",
                     {in_ready, out_valid, out_chan, acc_out, out_ovf, ovf_sticky});
        else
            n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        else
            n_pass++;
    endtask

    task automatic test_add();
        cmd(3'd0, 2'b00, 5'd10);
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'd0, 8'd10, 1'b0})
            $display("FAIL add_first: got v=%b ch=%0d acc=%0d ovf=%b, required v=1 ch=0 acc=10 ovf=0",
                     out_valid, out_chan, acc_out, out_ovf);
        else
            n_pass++;
        cmd(3'd0, 2'b00, 5'd5);
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'd0, 8'd15, 1'b0})
            $display("FAIL add_second: got v=%b ch=%0d acc=%0d ovf=%b, required v=1 ch=0 acc=15 ovf=0",
                     out_valid, out_chan, acc_out, out_ovf);
        else
            n_pass++;
        for (int c = 1; c < 4; c++) begin
            cmd(3'(c), 2'b00, 5'd0);
            n_checks++;
            if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'(c), 8'd0, 1'b0})
                $display("FAIL add_untouched_ch%0d: got ch=%0d acc=%0d ovf=%b, required acc=0 ovf=0",
                         c, out_chan, acc_out, out_ovf);
            else
                n_pass++;
        end
        n_checks++;
        if (ovf_sticky !== 4'b0000)
            $display("FAIL add_sticky: got %b, required 0000", ovf_sticky);
        else
            n_pass++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_val;
        cmd(3'd2, 2'b10, 5'd31);
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'd2, 8'd31, 1'b0})
            $display("FAIL wrap_load: got ch=%0d acc=%0d ovf=%b, required ch=2 acc=31 ovf=0",
                     out_chan, acc_out, out_ovf);
        else
            n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) exp_val = 8'(31 * (k + 2));
            else       exp_val = SAT ? 8'd255 : 8'd23;
            cmd(3'd2, 2'b00, 5'd31);
            n_checks++;
            if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'd2, exp_val, (k == 7)})
                $display("FAIL wrap_add%0d: got acc=%0d ovf=%b, required acc=%0d ovf=%b",
                         k + 1, acc_out, out_ovf, exp_val, (k == 7));
            else
                n_pass++;
        end
        n_checks++;
        if (ovf_sticky !== 4'b0100)
            $display("FAIL wrap_sticky_set: got %b, required 0100", ovf_sticky);
        else
            n_pass++;
        cmd(3'd2, 2'b10, 5'd31);
        n_checks++;
        if ({acc_out, out_ovf, ovf_sticky} !== {8'd31, 1'b0, 4'b0000})
            $display("FAIL wrap_load_clears_sticky: got acc=%0d ovf=%b sticky=%b, required 31 0 0000",
                     acc_out, out_ovf, ovf_sticky);
        else
            n_pass++;
    endtask

    task automatic test_sub();
        logic [AW-1:0] exp_val;
        exp_val = SAT ? 8'd0 : 8'd253;
        cmd(3'd1, 2'b01, 5'd3);
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf, ovf_sticky} !== {1'b1, 3'd1, exp_val, 1'b1, 4'b0010})
            $display("FAIL sub_underflow: got ch=%0d acc=%0d ovf=%b sticky=%b, required ch=1 acc=%0d ovf=1 sticky=0010",
                     out_chan, acc_out, out_ovf, ovf_sticky, exp_val);
        else
            n_pass++;
        cmd(3'd1, 2'b11, 5'd17);
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf, ovf_sticky} !== {1'b1, 3'd1, 8'd0, 1'b0, 4'b0000})
            $display("FAIL sub_clear: got ch=%0d acc=%0d ovf=%b sticky=%b, required ch=1 acc=0 ovf=0 sticky=0000",
                     out_chan, acc_out, out_ovf, ovf_sticky);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge pclk);
        out_ready = 1'b0;
        cmd(3'd3, 2'b10, 5'd7);
        in_valid = 1'b1;
        in_chan  = 3'd3;
        in_op    = 2'b00;
        acc_in   = 5'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            n_checks++;
            if ({in_ready, out_valid, out_chan, acc_out, out_ovf} !== {1'b0, 1'b1, 3'd3, 8'd7, 1'b0})
                $display("FAIL hold_cycle%0d: got rdy=%b v=%b ch=%0d acc=%0d, required rdy=0 v=1 ch=3 acc=7",
                         k, in_ready, out_valid, out_chan, acc_out);
            else
                n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL hold_release_ready: in_ready=%b, required 1", in_ready);
        else
            n_pass++;
        @(posedge pclk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'd3, 8'd8, 1'b0})
            $display("FAIL hold_replace: got v=%b ch=%0d acc=%0d, required v=1 ch=3 acc=8",
                     out_valid, out_chan, acc_out);
        else
            n_pass++;
        @(posedge pclk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL hold_single_transfer: out_valid=%b, required 0", out_valid);
        else
            n_pass++;
    endtask

    task automatic test_enable();
        out_ready = 1'b0;
        cmd(3'd0, 2'b10, 5'd20);
        clock_enable = 1'b0;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        in_chan      = 3'd0;
        in_op        = 2'b00;
        acc_in       = 5'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            n_checks++;
            if ({in_ready, out_valid, out_chan, acc_out, out_ovf} !== {1'b0, 1'b1, 3'd0, 8'd20, 1'b0})
                $display("FAIL enable_gap%0d: got rdy=%b v=%b acc=%0d, required rdy=0 v=1 acc=20",
                         k, in_ready, out_valid, acc_out);
            else
                n_pass++;
        end
        clock_enable = 1'b1;
        @(posedge pclk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'd0, 8'd21, 1'b0})
            $display("FAIL enable_resume: got v=%b acc=%0d, required v=1 acc=21", out_valid, acc_out);
        else
            n_pass++;
        cmd(3'd0, 2'b00, 5'd0);
        n_checks++;
        if (acc_out !== 8'd21)
            $display("FAIL enable_readback: got acc=%0d, required 21", acc_out);
        else
            n_pass++;
    endtask

    task automatic test_mid_reset();
        cmd(3'd1, 2'b01, 5'd3);
        out_ready = 1'b0;
        @(negedge pclk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0)
            $display("FAIL midreset_ready: in_ready=%b, required 0", in_ready);
        else
            n_pass++;
        @(posedge pclk);
        #1;
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf, ovf_sticky} !== 17'b0)
            $display("FAIL midreset_outputs: got %b, required all zero",
                     {out_valid, out_chan, acc_out, out_ovf, ovf_sticky});
        else
            n_pass++;
        @(negedge pclk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cmd(3'(c), 2'b00, 5'd0);
            n_checks++;
            if ({out_valid, out_chan, acc_out, out_ovf} !== {1'b1, 3'(c), 8'd0, 1'b0})
                $display("FAIL midreset_ch%0d: got acc=%0d ovf=%b, required acc=0 ovf=0",
                         c, acc_out, out_ovf);
            else
                n_pass++;
        end
    endtask

    task automatic test_bad_chan();
        @(negedge pclk);
        cmd(3'd5, 2'b10, 5'd9);
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL badchan_no_result: out_valid=%b, required 0", out_valid);
        else
            n_pass++;
        cmd(3'd1, 2'b00, 5'd0);
        n_checks++;
        if ({out_valid, out_chan, acc_out, out_ovf, ovf_sticky} !== {1'b1, 3'd1, 8'd0, 1'b0, 4'b0000})
            $display("FAIL badchan_no_alias: got ch=%0d acc=%0d sticky=%b, required ch=1 acc=0 sticky=0000",
                     out_chan, acc_out, ovf_sticky);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_back_to_back();
        test_enable();
        test_mid_reset();
        test_bad_chan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
